// File: rtl/axi_lite_regbank_slave.sv
// axi_lite_regbank_slave
//   AXI4-Lite slave exposing NUM_REGS registers of AXI_DATA_WIDTH bits.
//   Write address and write data are captured independently (either order)
//   and committed together. Registers flagged in RO_MASK are read from reg_in,
//   reject writes with SLVERR, and keep zero storage.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data and response channels
//   S_AXI_AR* / S_AXI_R*            : read address and data channels
//   reg_out  : flattened register contents, register i at [i*DW +: DW]
//   reg_in   : hardware values returned for read-only registers
//   wr_pulse : one-cycle pulse per successful register write
//   rd_pulse : one-cycle pulse per successful register read
module axi_lite_regbank_slave #(
  parameter int                  AXI_DATA_WIDTH = 32,
  parameter int                  AXI_ADDR_WIDTH = 8,
  parameter int                  NUM_REGS       = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                wr_pulse,
  output logic [NUM_REGS-1:0]                rd_pulse
);

  localparam int unsigned DW       = AXI_DATA_WIDTH;
  localparam int unsigned NB       = AXI_DATA_WIDTH / 8;
  localparam int unsigned NR       = NUM_REGS;
  localparam int          ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AXI_ADDR_WIDTH:0] LIMIT = (AXI_ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DW-1:0]             r_regs [NUM_REGS];
  logic                      r_live;
  logic                      r_aw_full;
  logic                      r_w_full;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [DW-1:0]             r_wdata;
  logic [NB-1:0]             r_wstrb;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic [NUM_REGS-1:0]       r_wr_pulse;
  logic                      r_rvalid;
  logic [1:0]                r_rresp;
  logic [DW-1:0]             r_rdata;
  logic [NUM_REGS-1:0]       r_rd_pulse;

  logic                      w_awready;
  logic                      w_wready;
  logic                      w_arready;
  logic [AXI_ADDR_WIDTH-1:0] w_aw_idx;
  logic [IDX_W-1:0]          w_aw_sel;
  logic                      w_aw_ok;
  logic [AXI_ADDR_WIDTH-1:0] w_ar_idx;
  logic [IDX_W-1:0]          w_ar_sel;
  logic                      w_ar_in_range;
  logic                      w_unused;

  // Readies stay low until one clock edge has passed after reset release.
  assign w_awready = r_live & ~r_aw_full & ~r_bvalid;
  assign w_wready  = r_live & ~r_w_full  & ~r_bvalid;
  assign w_arready = r_live & ~r_rvalid;

  assign w_aw_idx = r_awaddr >> ADDR_LSB;
  assign w_aw_sel = w_aw_idx[IDX_W-1:0];
  // Range test comes first so RO_MASK is only consulted for a valid index.
  assign w_aw_ok  = ({1'b0, w_aw_idx} < LIMIT) && !RO_MASK[w_aw_sel];

  assign w_ar_idx      = S_AXI_ARADDR >> ADDR_LSB;
  assign w_ar_sel      = w_ar_idx[IDX_W-1:0];
  assign w_ar_in_range = ({1'b0, w_ar_idx} < LIMIT);

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, r_awaddr[ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_live <= 1'b0;
    else                r_live <= 1'b1;
  end

  // Write channel. Commit only happens with both flags set, and flags can only
  // be set while BVALID is low, so commit and BREADY never coincide.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < NR; i++) r_regs[i] <= '0;
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
      if (S_AXI_AWVALID && w_awready) begin
        r_awaddr  <= S_AXI_AWADDR;
        r_aw_full <= 1'b1;
      end
      if (S_AXI_WVALID && w_wready) begin
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
        r_w_full <= 1'b1;
      end
      if (r_aw_full && r_w_full) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_aw_ok) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (r_wstrb[b]) r_regs[w_aw_sel][b*8 +: 8] <= r_wdata[b*8 +: 8];
          end
          r_bresp              <= RESP_OKAY;
          r_wr_pulse[w_aw_sel] <= 1'b1;
        end else begin
          r_bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read channel. Reads sample r_regs before any same-edge write commit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_rd_pulse <= '0;
    end else begin
      r_rd_pulse <= '0;
      if (r_rvalid && S_AXI_RREADY) r_rvalid <= 1'b0;
      if (S_AXI_ARVALID && w_arready) begin
        r_rvalid <= 1'b1;
        if (w_ar_in_range) begin
          r_rdata              <= RO_MASK[w_ar_sel] ? reg_in[w_ar_sel*DW +: DW]
                                                    : r_regs[w_ar_sel];
          r_rresp              <= RESP_OKAY;
          r_rd_pulse[w_ar_sel] <= 1'b1;
        end else begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = r_regs[g];
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign wr_pulse      = r_wr_pulse;
  assign rd_pulse      = r_rd_pulse;

endmodule

// File: tb/tb_axi_lite_regbank_slave.sv
// Testbench for axi_lite_regbank_slave: 16 x 32-bit registers, register 3
// read-only. Expected responses are queued when a transaction is issued and
// compared when the DUT responds.
module tb_axi_lite_regbank_slave;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   awaddr = '0;
  logic [2:0]      awprot = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [AW-1:0]   araddr = '0;
  logic [2:0]      arprot = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in;
  logic [NR-1:0]   wr_pulse;
  logic [NR-1:0]   rd_pulse;

  always #5 clk = ~clk;

  axi_lite_regbank_slave #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR),
    .RO_MASK(16'h0008)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  typedef struct packed {
    logic [1:0]    resp;
    logic [NR-1:0] pulse;
  } b_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [NR-1:0] pulse;
  } r_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_regs [NR];
  b_exp_t      b_q [$];
  r_exp_t      r_q [$];

  function automatic b_exp_t model_write(input logic [7:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
    b_exp_t e;
    int idx;
    idx = int'(a) / 4;
    if (idx >= NR || idx == 3) begin
      e.resp  = 2'b10;
      e.pulse = '0;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) exp_regs[idx][b*8 +: 8] = d[b*8 +: 8];
      e.resp  = 2'b00;
      e.pulse = 16'(1) << idx;
    end
    return e;
  endfunction

  function automatic r_exp_t model_read(input logic [7:0] a);
    r_exp_t e;
    int idx;
    idx = int'(a) / 4;
    if (idx >= NR) begin
      e.data = '0; e.resp = 2'b10; e.pulse = '0;
    end else if (idx == 3) begin
      e.data = reg_in[3*DW +: DW]; e.resp = 2'b00; e.pulse = 16'h0008;
    end else begin
      e.data = exp_regs[idx]; e.resp = 2'b00; e.pulse = 16'(1) << idx;
    end
    return e;
  endfunction

  function automatic logic [NR*DW-1:0] exp_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = exp_regs[i];
    return f;
  endfunction

  task automatic hs_aw(input logic [7:0] a, input string nm);
    int n;
    n = 0;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (awready !== 1'b1) begin
      errors++; $display("FAIL %s awready timeout: got %b want 1", nm, awready);
    end
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s, input string nm);
    int n;
    n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (wready !== 1'b1) begin
      errors++; $display("FAIL %s wready timeout: got %b want 1", nm, wready);
    end
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic collect_b(input string nm, output int lat);
    b_exp_t e;
    int n;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    lat = n;
    e = b_q.pop_front();
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL %s bvalid timeout: got %b want 1", nm, bvalid);
    end
    checks++;
    if (bresp !== e.resp) begin
      errors++; $display("FAIL %s bresp: got %b want %b", nm, bresp, e.resp);
    end
    checks++;
    if (wr_pulse !== e.pulse) begin
      errors++; $display("FAIL %s wr_pulse: got %h want %h", nm, wr_pulse, e.pulse);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    checks++;
    if ({bvalid, wr_pulse} !== 17'h0) begin
      errors++; $display("FAIL %s b clear: got bvalid=%b wr_pulse=%h want 0/0", nm, bvalid, wr_pulse);
    end
    checks++;
    if (reg_out !== exp_flat()) begin
      errors++; $display("FAIL %s reg_out: got %h want %h", nm, reg_out, exp_flat());
    end
  endtask

  task automatic collect_r(input string nm);
    r_exp_t e;
    int n;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    e = r_q.pop_front();
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL %s rvalid timeout: got %b want 1", nm, rvalid);
    end
    checks++;
    if ({rdata, rresp} !== {e.data, e.resp}) begin
      errors++; $display("FAIL %s rdata/rresp: got %h/%b want %h/%b", nm, rdata, rresp, e.data, e.resp);
    end
    checks++;
    if (rd_pulse !== e.pulse) begin
      errors++; $display("FAIL %s rd_pulse: got %h want %h", nm, rd_pulse, e.pulse);
    end
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    checks++;
    if ({rvalid, rd_pulse} !== 17'h0) begin
      errors++; $display("FAIL %s r clear: got rvalid=%b rd_pulse=%h want 0/0", nm, rvalid, rd_pulse);
    end
  endtask

  // mode 0: AW and W together, 1: W three cycles before AW, 2: AW first.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input string nm);
    int lat;
    b_q.push_back(model_write(a, d, s));
    if (mode == 0) begin
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      checks++;
      if ({awready, wready} !== 2'b11) begin
        errors++; $display("FAIL %s readies: got %b want 11", nm, {awready, wready});
      end
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (mode == 1) begin
      hs_w(d, s, nm);
      repeat (3) @(negedge clk);
      hs_aw(a, nm);
    end else begin
      hs_aw(a, nm);
      repeat (3) @(negedge clk);
      hs_w(d, s, nm);
    end
    collect_b(nm, lat);
    if (mode == 0) begin
      checks++;
      if (lat != 1) begin
        errors++; $display("FAIL %s latency: got %0d want 1", nm, lat);
      end
    end
  endtask

  task automatic do_read(input logic [7:0] a, input string nm);
    int n;
    n = 0;
    r_q.push_back(model_read(a));
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL %s arready timeout: got %b want 1", nm, arready);
    end
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    collect_r(nm);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bvalid, rvalid, bresp, rresp, rdata, wr_pulse, rd_pulse, awready, wready, arready} !== '0) begin
      errors++; $display("FAIL reset outputs: got bv=%b rv=%b br=%b rr=%b rd=%h wp=%h rp=%h rdy=%b want all 0",
                         bvalid, rvalid, bresp, rresp, rdata, wr_pulse, rd_pulse, {awready, wready, arready});
    end
    checks++;
    if (reg_out !== '0) begin
      errors++; $display("FAIL reset reg_out: got %h want 0", reg_out);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_release readies: got %b want 000", {awready, wready, arready});
    end
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL live readies: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, "same_cycle_wr");
    do_read(8'h08, "same_cycle_rd");
  endtask

  task automatic test_write_order();
    do_write(8'h04, 32'hFFFFFFFF, 4'hF, 0, "order_init1");
    do_write(8'h04, 32'h12345678, 4'h5, 1, "w_first");
    do_read(8'h04, "w_first_rd");
    do_write(8'h04, 32'hFFFFFFFF, 4'hF, 0, "order_init2");
    do_write(8'h04, 32'h12345678, 4'h5, 2, "aw_first");
    do_read(8'h04, "aw_first_rd");
  endtask

  task automatic test_read_only();
    do_write(8'h0C, 32'h55555555, 4'hF, 0, "ro_wr");
    do_read(8'h0C, "ro_rd");
  endtask

  task automatic test_out_of_range();
    do_write(8'h40, 32'hA5A5A5A5, 4'hF, 2, "oor_wr");
    do_read(8'h40, "oor_rd");
    do_read(8'h3F, "last_reg_rd");
  endtask

  task automatic test_zero_strobe();
    do_write(8'h08, 32'h00000000, 4'h0, 0, "zero_strb");
    do_read(8'h08, "zero_strb_rd");
  endtask

  task automatic test_back_to_back();
    do_write(8'h18, 32'h01020304, 4'hF, 0, "b2b_wr0");
    do_write(8'h1C, 32'hA0B0C0D0, 4'hC, 1, "b2b_wr1");
    do_read(8'h18, "b2b_rd0");
    do_read(8'h1C, "b2b_rd1");
  endtask

  task automatic test_backpressure();
    b_exp_t be;
    r_exp_t re;
    int n;
    r_q.push_back(model_read(8'h08));
    b_q.push_back(model_write(8'h10, 32'h0BADF00D, 4'hF));
    awaddr = 8'h10; wdata = 32'h0BADF00D; wstrb = 4'hF; araddr = 8'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    re = r_q.pop_front();
    checks++;
    if ({rvalid, rdata, rresp, rd_pulse} !== {1'b1, re.data, re.resp, re.pulse}) begin
      errors++; $display("FAIL bp_read: got rv=%b %h/%b rp=%h want 1 %h/%b rp=%h",
                         rvalid, rdata, rresp, rd_pulse, re.data, re.resp, re.pulse);
    end
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    be = b_q.pop_front();
    checks++;
    if ({bvalid, bresp, wr_pulse} !== {1'b1, be.resp, be.pulse}) begin
      errors++; $display("FAIL bp_write: got bv=%b br=%b wp=%h want 1 %b %h",
                         bvalid, bresp, wr_pulse, be.resp, be.pulse);
    end
    awaddr = 8'h14; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, rvalid, rdata, rresp, bresp} !== {1'b1, 1'b1, re.data, re.resp, be.resp}) begin
        errors++; $display("FAIL bp_hold cycle %0d: got bv=%b rv=%b %h/%b br=%b want 1 1 %h/%b %b",
                           i, bvalid, rvalid, rdata, rresp, bresp, re.data, re.resp, be.resp);
      end
      checks++;
      if ({awready, wready, arready} !== 3'b000) begin
        errors++; $display("FAIL bp_readies cycle %0d: got %b want 000", i, {awready, wready, arready});
      end
      @(negedge clk);
    end
    awvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      errors++; $display("FAIL bp_release: got bv=%b rv=%b want 0 0", bvalid, rvalid);
    end
    checks++;
    if (reg_out !== exp_flat()) begin
      errors++; $display("FAIL bp_reg_out: got %h want %h", reg_out, exp_flat());
    end
  endtask

  task automatic test_reset_mid();
    logic seen_b;
    hs_aw(8'h10, "mid_aw");
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    checks++;
    if ({bvalid, rvalid, bresp, rresp, rdata, wr_pulse, rd_pulse, awready, wready, arready} !== '0) begin
      errors++; $display("FAIL mid_reset outputs: got bv=%b rv=%b rdy=%b rd=%h want all 0",
                         bvalid, rvalid, {awready, wready, arready}, rdata);
    end
    checks++;
    if (reg_out !== '0) begin
      errors++; $display("FAIL mid_reset reg_out: got %h want 0", reg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL mid_release readies: got %b want 000", {awready, wready, arready});
    end
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL mid_live readies: got %b want 111", {awready, wready, arready});
    end
    b_q.push_back(model_write(8'h14, 32'h11111111, 4'hF));
    hs_w(32'h11111111, 4'hF, "mid_w");
    seen_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen_b |= bvalid;
      @(negedge clk);
    end
    checks++;
    if (seen_b !== 1'b0 || reg_out !== '0) begin
      errors++; $display("FAIL stale_commit: got bvalid_seen=%b reg_out=%h want 0/0", seen_b, reg_out);
    end
    begin
      int lat;
      hs_aw(8'h14, "mid_aw2");
      collect_b("mid_commit", lat);
    end
  endtask

  initial begin
    reg_in = '0;
    for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = 32'hA5A50000 | 32'(i);
    reg_in[3*DW +: DW] = 32'hCAFE0001;
    test_reset();
    test_write_same_cycle();
    test_write_order();
    test_read_only();
    test_out_of_range();
    test_zero_strobe();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_lite_regbank_slave.md
Name: axi_lite_regbank_slave

Overview:
Parametrised AXI4-Lite register bank, successor to the fixed 4-register slave template.
- Register count, data width and address width are parameters.
- Write address and write data are accepted independently and in either order.
- Per-register read-only mask; read-only registers are sourced from hardware inputs.
- SLVERR on out-of-range or read-only writes.
- One-cycle write/read notification pulses to user logic.
- Sits between the AXI-Lite interconnect and a peripheral's control/status logic.

Parameters:
AXI_DATA_WIDTH, 32, data bus width; 32 or 64 only.
AXI_ADDR_WIDTH, 8, byte address width; must be >= ADDR_LSB + clog2(NUM_REGS).
NUM_REGS, 16, number of registers, 1..256.
RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only, sourced from reg_in.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read valid
S_AXI_RREADY  in  1  read ready
reg_out  out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents; register i at [i*DW +: DW]
reg_in  in  NUM_REGS*AXI_DATA_WIDTH  hardware values for read-only registers
wr_pulse  out  NUM_REGS  one-cycle pulse per successful write
rd_pulse  out  NUM_REGS  one-cycle pulse per successful read

Behaviour:
- Reset (async assert, sync release via flops):
  - All registers, BVALID, RVALID, RDATA, BRESP, RRESP, wr_pulse and rd_pulse = 0.
  - Internal aw_full / w_full holding flags = 0.
  - A "live" flop clears on reset and sets on the first clock edge after release; AWREADY, WREADY and ARREADY are 0 while live = 0.
  - Reset mid-transaction aborts it: no register update, no response.
- Decode:
  - ADDR_LSB = clog2(DW/8).
  - idx = addr >> ADDR_LSB.
  - In range iff idx < NUM_REGS. Low ADDR_LSB bits are ignored.
- Write channel:
  - AWREADY = live & ~aw_full & ~BVALID.
  - WREADY = live & ~w_full & ~BVALID.
  - An AW handshake latches the address and sets aw_full; a W handshake latches data and strobe and sets w_full. The two may occur in the same or different cycles, in either order.
  - Commit happens on the edge where aw_full & w_full:
    - In-range and RW register: apply byte strobes, BRESP = 00, wr_pulse[idx] = 1 for one cycle.
    - Out-of-range or RO register: no update, BRESP = 10, no pulse.
    - Both flags clear; BVALID = 1.
  - WSTRB = 0 to an RW register: no change, OKAY, pulse still asserted.
  - BVALID holds until BREADY; no new AW or W is accepted while BVALID = 1.
  - Latency: last handshake at edge E gives BVALID at E+1. Minimum 3 cycles per write with BREADY tied high.
- Read channel:
  - ARREADY = live & ~RVALID.
  - On an AR handshake the next edge loads RDATA and sets RVALID:
    - In-range: RDATA = RO_MASK[idx] ? reg_in slice : register; RRESP = 00; rd_pulse[idx] = 1 for one cycle.
    - Out-of-range: RDATA = 0, RRESP = 10, no pulse.
  - RDATA and RRESP stay stable while RVALID & ~RREADY; RVALID clears on RREADY.
  - Throughput: 1 read per 2 cycles.
- Read and write channels run independently.
  - A read sampled on the same edge as a write commit to the same register returns the pre-write value.
- RO register storage stays 0; reg_out for RO slots = 0.

Test Plan:
- Reset, then AW and W same cycle, addr 0x08, data 0xDEADBEEF, strb 0xF -> BVALID two edges later, BRESP 00, reg 2 = 0xDEADBEEF, wr_pulse = 0x0004 for one cycle; readback RDATA 0xDEADBEEF, RRESP 00, rd_pulse[2] = 1.
- W given 3 cycles before AW (addr 0x04, data 0x12345678, strb 0x5) onto reg 1 = 0xFFFFFFFF -> reg 1 = 0xFF34FF78. Same test with AW first gives the same result.
- RO_MASK = 0x0008, reg_in slot 3 = 0xCAFE0001: write 0x0C -> BRESP 10, no pulse; read 0x0C -> 0xCAFE0001, RRESP 00.
- Addr 0x40 with NUM_REGS = 16, both write and read -> BRESP 10, RRESP 10, RDATA 0, all registers unchanged, no pulses.
- BREADY and RREADY held low 5 cycles -> BVALID, RVALID, RDATA and RRESP stable; AWREADY, WREADY and ARREADY stay 0 throughout; a new AW presented during this time is not accepted.
- ARESETN pulsed low while aw_full = 1 and w_full = 0 -> outputs 0 asynchronously; readies stay 0 for one cycle after release; the stale address is not committed by a later W.
